// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned COUNT_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

    typedef enum logic {
        FETCH,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load; resets to a bubble.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               load,
    input  logic               bubble,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic               valid
);
    if_id_t q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= IF_ID_BUBBLE;
        end else if (bubble) begin
            q <= IF_ID_BUBBLE;
        end else if (hold) begin
            q <= q;
        end else if (load) begin
            q <= '{pc: pc_in, instr: instr_in, valid: 1'b1};
        end
    end

    assign pc    = q.pc;
    assign instr = q.instr;
    assign valid = q.valid;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, fetch/halt FSM, ROM bounds check and retired-fetch counter.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_target,
    output logic [63:0]  imem_addr,
    input  logic [31:0]  imem_instr,
    output logic [63:0]  if_id_pc,
    output logic [31:0]  if_id_instr,
    output logic         if_id_valid,
    output logic         halted,
    output logic [31:0]  fetch_count
);
    fetch_state_t        state, state_next;
    logic [PC_W-1:0]     pc, pc_next;
    logic [COUNT_W-1:0]  count;
    logic                pc_bad;
    logic                ifid_hold, ifid_load, ifid_bubble, count_inc;

    // Misaligned, or any byte of the word lies past the end of the ROM.
    assign pc_bad = (pc[1:0] != 2'b00) || ((pc + PC_W'(3)) >= PC_W'(MEM_SIZE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (count_inc) begin
                count <= count + COUNT_W'(1);
            end
        end
    end

    // Priority in FETCH: redirect > bad PC > stall > advance.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        ifid_hold   = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        count_inc   = 1'b0;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_next     = redirect_target;
                    ifid_bubble = 1'b1;
                end else if (pc_bad) begin
                    state_next  = HALTED;
                    ifid_bubble = 1'b1;
                end else if (stall) begin
                    ifid_hold   = 1'b1;
                end else begin
                    pc_next     = pc + PC_W'(4);
                    ifid_load   = 1'b1;
                    count_inc   = 1'b1;
                end
            end
            HALTED: begin
                ifid_bubble = 1'b1;
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next  = FETCH;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .hold     (ifid_hold),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .pc_in    (pc),
        .instr_in (imem_instr),
        .pc       (if_id_pc),
        .instr    (if_id_instr),
        .valid    (if_id_valid)
    );

    assign imem_addr   = pc;
    assign halted      = (state == HALTED);
    assign fetch_count = count;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural reference and an IF/ID scoreboard.
module tb_instruction_fetch;
    localparam int unsigned MEM_SIZE = 1024;
    localparam logic [31:0] NOP      = 32'hD503201F;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] rom [0:255];
    logic [7:0]  rom_idx;

    exp_t        sb[$];
    exp_t        m_ifid;
    logic [63:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_halted;

    int n_cmp = 0;
    int n_mis = 0;

    instruction_fetch #(.RESET_PC(64'd0), .MEM_SIZE(MEM_SIZE)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    assign rom_idx    = imem_addr[9:2];
    assign imem_instr = rom[rom_idx];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        logic [7:0] i;
        i = a[9:2];
        return rom[i];
    endfunction

    function automatic logic is_bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a + 64'd3 >= 64'(MEM_SIZE));
    endfunction

    task automatic model_reset();
        m_pc     = 64'd0;
        m_cnt    = 32'd0;
        m_halted = 1'b0;
        m_ifid   = '{pc: 64'd0, instr: NOP, valid: 1'b0};
        sb.delete();
    endtask

    // Drive one cycle, predict IF/ID into the scoreboard, then compare after the edge.
    task automatic step(input logic st, input logic rv, input logic [63:0] tgt);
        exp_t e;
        exp_t got;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = tgt;
        e = '{pc: 64'd0, instr: NOP, valid: 1'b0};
        if (!m_halted) begin
            if (rv) begin
                m_pc = tgt;
            end else if (is_bad(m_pc)) begin
                m_halted = 1'b1;
            end else if (st) begin
                e = m_ifid;
            end else begin
                e = '{pc: m_pc, instr: rom_word(m_pc), valid: 1'b1};
                m_pc  = m_pc + 64'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end else if (rv) begin
            m_pc     = tgt;
            m_halted = 1'b0;
        end
        m_ifid = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("if_id_pc",    if_id_pc,           got.pc);
        check("if_id_instr", 64'(if_id_instr),   64'(got.instr));
        check("if_id_valid", 64'(if_id_valid),   64'(got.valid));
        check("imem_addr",   imem_addr,          m_pc);
        check("halted",      64'(halted),        64'(m_halted));
        check("fetch_count", 64'(fetch_count),   64'(m_cnt));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  imem_addr,         64'd0);
        check({tag, "_valid"}, 64'(if_id_valid),  64'd0);
        check({tag, "_instr"}, 64'(if_id_instr),  64'(NOP));
        check({tag, "_pc"},    if_id_pc,          64'd0);
        check({tag, "_halt"},  64'(halted),       64'd0);
        check({tag, "_cnt"},   64'(fetch_count),  64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h5000_0000 | 32'(i);
        rom[0] = 32'hA; rom[1] = 32'hB; rom[2] = 32'hC; rom[3] = 32'hD;

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 64'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b0;

        // Free run over the first four words.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'd0);
        check("run4_pc",    if_id_pc,             64'd12);
        check("run4_instr", 64'(if_id_instr),     64'hD);
        check("run4_cnt",   64'(fetch_count),     64'd4);

        // Back to 0, fetch two, then stall at pc=8.
        step(1'b0, 1'b1, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'd0);
        check("stall_addr", imem_addr,        64'd8);
        check("stall_pc",   if_id_pc,         64'd4);
        check("stall_cnt",  64'(fetch_count), 64'd6);
        step(1'b0, 1'b0, 64'd0);
        check("resume_pc",  if_id_pc,         64'd8);

        // Redirect wins over stall.
        step(1'b1, 1'b1, 64'h40);
        check("redir_addr",  imem_addr,        64'h40);
        check("redir_valid", 64'(if_id_valid), 64'd0);
        step(1'b0, 1'b0, 64'd0);
        check("redir_pc",    if_id_pc,         64'h40);
        check("redir_instr", 64'(if_id_instr), 64'h5000_0010);

        // Run off the end of the ROM.
        while (m_pc != 64'(MEM_SIZE)) step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        check("end_halt",  64'(halted),      64'd1);
        step(1'b1, 1'b0, 64'd0);
        check("end_hold",  imem_addr,        64'(MEM_SIZE));
        step(1'b0, 1'b1, 64'd0);
        check("unhalt",    64'(halted),      64'd0);
        step(1'b0, 1'b0, 64'd0);
        check("refetch0",  64'(if_id_instr), 64'hA);

        // Misaligned redirect halts one edge later.
        step(1'b0, 1'b1, 64'd6);
        step(1'b0, 1'b0, 64'd0);
        check("mis_halt",  64'(halted),      64'd1);
        step(1'b0, 1'b1, 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'd0);

        // Asynchronous reset between edges, released while stalled.
        #2;
        reset = 1'b1;
        stall = 1'b1;
        #1;
        check_reset_values("arst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        check("arst_first_pc",    if_id_pc,         64'd0);
        check("arst_first_instr", 64'(if_id_instr), 64'hA);
        step(1'b0, 1'b0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
